// File: rtl/broaden_pulse_recover.sv
// rtl/broaden_pulse_recover.sv - resynchronise, width-qualify and count broadened pulses
// Optional macro BROADEN_RECOVER_MAXLEN_EN: accept on the falling edge with an upper width bound.
module broaden_pulse_recover #(
    parameter int LAT     = 2,
    parameter int MIN_LEN = 4,
    parameter int MAX_LEN = 16,
    parameter int CW      = 8
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic          d,
    output logic          q_pulse,
    output logic          cnt_vld,
    input  logic          cnt_rdy,
    output logic [CW-1:0] cnt,
    output logic          ovf
);

    localparam int WCW = $clog2(MAX_LEN + 2);
    localparam logic [WCW-1:0] WC_SAT = WCW'(MAX_LEN + 1);
    localparam logic [WCW-1:0] WC_ONE = WCW'(1);
`ifdef BROADEN_RECOVER_MAXLEN_EN
    localparam logic [WCW-1:0] WC_MIN = WCW'(MIN_LEN);
    localparam logic [WCW-1:0] WC_MAX = WCW'(MAX_LEN);
`else
    localparam logic [WCW-1:0] WC_ACC = WCW'(MIN_LEN - 1);
`endif
    localparam logic [CW-1:0] ACC_MAX = '1;
    localparam logic [CW-1:0] ACC_ONE = CW'(1);

    typedef enum logic [1:0] {IDLE, MEAS, HOLD} state_t;

    state_t         state;
    logic [WCW-1:0] wc;
    logic [LAT-1:0] sync;
    logic           ds;
    logic           accept;
    logic           hs;
    logic [CW-1:0]  acc;
    logic [CW-1:0]  acc_nxt;
    logic           ovf_nxt;

    // Shift toward the MSB; the cast drops the oldest bit.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) sync <= '0;
        else        sync <= LAT'({sync, d});
    end

    assign ds = sync[LAT-1];

    always_comb begin
        accept = 1'b0;
`ifdef BROADEN_RECOVER_MAXLEN_EN
        if (state == MEAS && !ds && wc >= WC_MIN && wc <= WC_MAX) accept = 1'b1;
`else
        if (state == MEAS && ds && wc == WC_ACC) accept = 1'b1;
`endif
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            wc      <= '0;
            q_pulse <= 1'b0;
        end else begin
            q_pulse <= accept;
            case (state)
                IDLE: begin
                    if (ds) begin
                        state <= MEAS;
                        wc    <= WC_ONE;
                    end
                end
                MEAS: begin
`ifdef BROADEN_RECOVER_MAXLEN_EN
                    if (ds) begin
                        if (wc != WC_SAT) wc <= wc + WC_ONE;
                    end else begin
                        state <= IDLE;
                        wc    <= '0;
                    end
`else
                    if (ds) begin
                        if (wc == WC_ACC)      state <= HOLD;
                        else if (wc != WC_SAT) wc <= wc + WC_ONE;
                    end else begin
                        state <= IDLE;
                        wc    <= '0;
                    end
`endif
                end
                HOLD: begin
                    if (!ds) begin
                        state <= IDLE;
                        wc    <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    wc    <= '0;
                end
            endcase
        end
    end

    assign hs = cnt_vld & cnt_rdy;

    // A handshake coinciding with an accept restarts the count at one so the event is kept.
    always_comb begin
        acc_nxt = acc;
        ovf_nxt = ovf;
        if (hs) begin
            acc_nxt = accept ? ACC_ONE : '0;
            ovf_nxt = 1'b0;
        end else if (accept) begin
            if (acc == ACC_MAX) ovf_nxt = 1'b1;
            else                acc_nxt = acc + ACC_ONE;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            ovf     <= 1'b0;
            cnt_vld <= 1'b0;
        end else begin
            acc     <= acc_nxt;
            ovf     <= ovf_nxt;
            cnt_vld <= (acc_nxt != '0);
        end
    end

    assign cnt = acc;

endmodule

// File: tb/tb_broaden_pulse_recover.sv
// tb/tb_broaden_pulse_recover.sv - directed self-checking bench for broaden_pulse_recover
module tb_broaden_pulse_recover;

    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic       d = 1'b0;
    logic       cnt_rdy = 1'b0;
    logic       cnt_rdy2 = 1'b0;
    logic       q_pulse, cnt_vld, ovf;
    logic [7:0] cnt;
    logic       q_pulse2, cnt_vld2, ovf2;
    logic [1:0] cnt2;

    int checks = 0;
    int errors = 0;
    int qcnt = 0;
    int qbase;

    always #5 clock = ~clock;

    broaden_pulse_recover dut (
        .clock(clock), .rst_n(rst_n), .d(d), .q_pulse(q_pulse),
        .cnt_vld(cnt_vld), .cnt_rdy(cnt_rdy), .cnt(cnt), .ovf(ovf)
    );

    broaden_pulse_recover #(.CW(2)) dut_sat (
        .clock(clock), .rst_n(rst_n), .d(d), .q_pulse(q_pulse2),
        .cnt_vld(cnt_vld2), .cnt_rdy(cnt_rdy2), .cnt(cnt2), .ovf(ovf2)
    );

    always @(negedge clock) if (q_pulse === 1'b1) qcnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse(input int len, input int gap);
        d = 1'b1;
        repeat (len) tick();
        d = 1'b0;
        repeat (gap) tick();
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("rst_q", q_pulse, 0);
        check("rst_vld", cnt_vld, 0);
        check("rst_cnt", cnt, 0);
        check("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        repeat (2) tick();

`ifdef BROADEN_RECOVER_MAXLEN_EN
        qbase = qcnt;
        pulse(20, 8);
        check("long_rej_q", qcnt - qbase, 0);
        check("long_rej_vld", cnt_vld, 0);
        d = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (i == 7) d = 1'b0;
            check($sformatf("mid_q_%0d", i), q_pulse, (i == 10) ? 1 : 0);
        end
        check("mid_cnt", cnt, 1);
        check("mid_vld", cnt_vld, 1);
`else
        d = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 3) d = 1'b0;
            check($sformatf("lat_q_%0d", i), q_pulse, (i == 5) ? 1 : 0);
            if (i == 5) begin
                check("lat_cnt", cnt, 1);
                check("lat_vld", cnt_vld, 1);
            end
        end
        check("hold_cnt", cnt, 1);
        check("hold_vld", cnt_vld, 1);
`endif

        cnt_rdy = 1'b1;
        tick();
        cnt_rdy = 1'b0;
        check("drain_cnt", cnt, 0);
        check("drain_vld", cnt_vld, 0);

        qbase = qcnt;
        pulse(3, 8);
        check("short_q", qcnt - qbase, 0);
        check("short_vld", cnt_vld, 0);
        cnt_rdy = 1'b1;
        tick();
        cnt_rdy = 1'b0;
        check("idle_rdy_cnt", cnt, 0);

        qbase = qcnt;
        repeat (3) pulse(4, 2);
        repeat (8) tick();
        check("three_q", qcnt - qbase, 3);
        check("three_cnt", cnt, 3);
        check("three_vld", cnt_vld, 1);
        cnt_rdy = 1'b1;
        tick();
        cnt_rdy = 1'b0;
        check("three_hs_cnt", cnt, 0);
        check("three_hs_vld", cnt_vld, 0);

`ifndef BROADEN_RECOVER_MAXLEN_EN
        repeat (2) pulse(4, 2);
        repeat (4) tick();
        check("two_cnt", cnt, 2);
        d = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i == 5) cnt_rdy = 1'b1;
            tick();
            if (i == 3) d = 1'b0;
            if (i == 5) begin
                cnt_rdy = 1'b0;
                check("coinc_q", q_pulse, 1);
                check("coinc_cnt", cnt, 1);
                check("coinc_vld", cnt_vld, 1);
            end
        end
        check("coinc_after_cnt", cnt, 1);
`endif

        cnt_rdy2 = 1'b1;
        tick();
        cnt_rdy2 = 1'b0;
        check("sat_clr_cnt", cnt2, 0);
        check("sat_clr_ovf", ovf2, 0);
        repeat (4) pulse(4, 2);
        repeat (6) tick();
        check("sat_cnt", cnt2, 3);
        check("sat_ovf", ovf2, 1);
        check("sat_vld", cnt_vld2, 1);
        check("nosat_ovf", ovf, 0);
        cnt_rdy2 = 1'b1;
        tick();
        cnt_rdy2 = 1'b0;
        check("sat_hs_cnt", cnt2, 0);
        check("sat_hs_ovf", ovf2, 0);
        check("sat_hs_vld", cnt_vld2, 0);

        d = 1'b1;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("arst_q", q_pulse, 0);
        check("arst_vld", cnt_vld, 0);
        check("arst_cnt", cnt, 0);
        check("arst_ovf", ovf, 0);
        check("arst_cnt2", cnt2, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 5) d = 1'b0;
        end
        repeat (4) tick();
        check("rerise_cnt", cnt, 1);
        check("rerise_vld", cnt_vld, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
